// File: rtl/adder32_resp_checker.sv
// Response checker for adder32: scores each applied vector against A+B+cin, keeps
// saturating pass/error counters and captures the first failure. Option: STOP_ON_ERR_EN.
module adder32_resp_checker #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] S_i,
    input  logic             C32_i,
    output logic             out_valid_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_flag_o,
    output logic             halted_o,
    output logic [WIDTH-1:0] fail_A_o,
    output logic [WIDTH-1:0] fail_B_o,
    output logic             fail_cin_o,
    output logic [WIDTH-1:0] fail_S_o,
    output logic             fail_C32_o
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t             state_q, state_d;
    logic               v1_q;
    logic [WIDTH-1:0]   a1_q, b1_q, s1_q;
    logic               cin1_q, c1_q;
    logic               ov_q, pass_q, halted_q;
    logic [CNT_W-1:0]   pass_cnt_q, err_cnt_q;
    logic [WIDTH-1:0]   fa_q, fb_q, fs_q;
    logic               fcin_q, fc_q;

    logic [WIDTH:0]     exp_w;
    logic               match, score, enter_err;

    // Stage-2 reference sum, one bit wider so the carry-out is compared too
    assign exp_w     = {1'b0, a1_q} + {1'b0, b1_q} + {{WIDTH{1'b0}}, cin1_q};
    assign match     = (exp_w == {c1_q, s1_q});
    assign score     = v1_q & ~halted_q;
    assign enter_err = score & ~match & (state_q != ERR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (score) begin
            case (state_q)
                IDLE, RUN: state_d = match ? RUN : ERR;
                default:   state_d = ERR;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            v1_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            s1_q       <= '0;
            cin1_q     <= 1'b0;
            c1_q       <= 1'b0;
            ov_q       <= 1'b0;
            pass_q     <= 1'b0;
            halted_q   <= 1'b0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            fa_q       <= '0;
            fb_q       <= '0;
            fs_q       <= '0;
            fcin_q     <= 1'b0;
            fc_q       <= 1'b0;
        end else begin
            v1_q <= in_valid_i & ~halted_q;
            // Only latch operands on valid cycles so idle-cycle X/Z never reaches the compare
            if (in_valid_i) begin
                a1_q   <= A_i;
                b1_q   <= B_i;
                s1_q   <= S_i;
                cin1_q <= cin_i;
                c1_q   <= C32_i;
            end
            ov_q   <= score;
            pass_q <= score & match;
            if (score && match && pass_cnt_q != '1)  pass_cnt_q <= pass_cnt_q + 1'b1;
            if (score && !match && err_cnt_q != '1)  err_cnt_q  <= err_cnt_q + 1'b1;
            if (enter_err) begin
                fa_q   <= a1_q;
                fb_q   <= b1_q;
                fs_q   <= s1_q;
                fcin_q <= cin1_q;
                fc_q   <= c1_q;
            end
`ifdef STOP_ON_ERR_EN
            if (enter_err) halted_q <= 1'b1;
`else
            halted_q <= 1'b0;
`endif
        end
    end

    assign out_valid_o = ov_q;
    assign pass_o      = pass_q;
    assign pass_cnt_o  = pass_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_flag_o  = (state_q == ERR);
    assign halted_o    = halted_q;
    assign fail_A_o    = fa_q;
    assign fail_B_o    = fb_q;
    assign fail_cin_o  = fcin_q;
    assign fail_S_o    = fs_q;
    assign fail_C32_o  = fc_q;

endmodule
